// File: rtl/mac_job_scheduler_pkg.sv
// Shared widths, FSM state encoding, the job descriptor and the ReLU helper for the
// MAC job scheduler slice.
package mac_job_scheduler_pkg;

    localparam int DATA_WIDTH    = 16;
    localparam int CLK_NUM_WIDTH = 8;
    localparam int ADDR_WIDTH    = 10;

    // Encoding matches the other conv controllers so state probes read the same everywhere.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_OUT   = 3'd4;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]    baseA;
        logic [ADDR_WIDTH-1:0]    baseB;
        logic [CLK_NUM_WIDTH-1:0] len;
    } job_t;

    // Any value with the sign bit set, including -0, clamps to +0.
    function automatic logic [DATA_WIDTH-1:0] reluHalf(input logic [DATA_WIDTH-1:0] value);
        return value[DATA_WIDTH-1] ? '0 : value;
    endfunction

endpackage

// File: rtl/mac_job_scheduler_if.sv
// Bundles the job, buffer-read, MAC and result signals of the scheduler.
// The slave modport is the scheduler's view; master is the surrounding system.
interface mac_job_scheduler_if;
    import mac_job_scheduler_pkg::*;

    logic                     job_valid;
    logic                     job_ready;
    logic [ADDR_WIDTH-1:0]    job_base_a;
    logic [ADDR_WIDTH-1:0]    job_base_b;
    logic [CLK_NUM_WIDTH-1:0] job_len;

    logic                     rd_en;
    logic [ADDR_WIDTH-1:0]    rd_addr_a;
    logic [ADDR_WIDTH-1:0]    rd_addr_b;
    logic [DATA_WIDTH-1:0]    rd_data_a;
    logic [DATA_WIDTH-1:0]    rd_data_b;

    logic [DATA_WIDTH-1:0]    mac_a;
    logic [DATA_WIDTH-1:0]    mac_b;
    logic [CLK_NUM_WIDTH-1:0] mac_clk_num;
    logic                     mac_result_ready;
    logic [DATA_WIDTH-1:0]    mac_result;

    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    out_data;
    logic                     busy;

    modport slave (
        input  job_valid, job_base_a, job_base_b, job_len,
        input  rd_data_a, rd_data_b, mac_result_ready, mac_result, out_ready,
        output job_ready, rd_en, rd_addr_a, rd_addr_b,
        output mac_a, mac_b, mac_clk_num, out_valid, out_data, busy
    );

    modport master (
        output job_valid, job_base_a, job_base_b, job_len,
        output rd_data_a, rd_data_b, mac_result_ready, mac_result, out_ready,
        input  job_ready, rd_en, rd_addr_a, rd_addr_b,
        input  mac_a, mac_b, mac_clk_num, out_valid, out_data, busy
    );

endinterface

// File: rtl/mac_job_addr_gen.sv
// Address generator for the scheduler: latches job bases, steps both read addresses
// once per fetch cycle (wrapping naturally at the address width) and flags the last pair.
module mac_job_addr_gen
    import mac_job_scheduler_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  job_t                  i_job,
    input  logic                  i_step,
    output logic [ADDR_WIDTH-1:0] o_rdAddrA,
    output logic [ADDR_WIDTH-1:0] o_rdAddrB,
    output logic                  o_lastPair
);

    logic [ADDR_WIDTH-1:0]    r_addrA;
    logic [ADDR_WIDTH-1:0]    r_addrB;
    logic [CLK_NUM_WIDTH-1:0] r_remaining;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addrA     <= '0;
            r_addrB     <= '0;
            r_remaining <= '0;
        end else if (i_load) begin
            r_addrA     <= i_job.baseA;
            r_addrB     <= i_job.baseB;
            r_remaining <= i_job.len;
        end else if (i_step) begin
            r_addrA     <= r_addrA + ADDR_WIDTH'(1);
            r_addrB     <= r_addrB + ADDR_WIDTH'(1);
            r_remaining <= r_remaining - CLK_NUM_WIDTH'(1);
        end
    end

    assign o_rdAddrA  = r_addrA;
    assign o_rdAddrB  = r_addrB;
    assign o_lastPair = (r_remaining == CLK_NUM_WIDTH'(1));

endmodule

// File: rtl/mac_job_scheduler.sv
// Sequences one float16 MAC for dot-product jobs: fetch operand pairs, drain, wait for the sum,
// hand it out on valid/ready. Define MAC_SCHED_RELU_EN to clamp negative results to +0.
module mac_job_scheduler
    import mac_job_scheduler_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    mac_job_scheduler_if.slave bus
);

    logic [2:0]               r_state;
    logic                     r_rdEnD;
    logic [DATA_WIDTH-1:0]    r_macA;
    logic [DATA_WIDTH-1:0]    r_macB;
    logic [DATA_WIDTH-1:0]    r_outData;
    logic [CLK_NUM_WIDTH-1:0] r_macClkNum;

    logic                     w_accept;
    logic                     w_fetch;
    logic                     w_lastPair;
    logic [ADDR_WIDTH-1:0]    w_rdAddrA;
    logic [ADDR_WIDTH-1:0]    w_rdAddrB;
    logic [DATA_WIDTH-1:0]    w_capture;
    job_t                     w_job;

    assign w_job    = '{baseA: bus.job_base_a, baseB: bus.job_base_b, len: bus.job_len};
    assign w_accept = (r_state == ST_IDLE) && bus.job_valid;
    assign w_fetch  = (r_state == ST_FETCH);

`ifdef MAC_SCHED_RELU_EN
    assign w_capture = reluHalf(bus.mac_result);
`else
    assign w_capture = bus.mac_result;
`endif

    mac_job_addr_gen u_addrGen (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_accept),
        .i_job      (w_job),
        .i_step     (w_fetch),
        .o_rdAddrA  (w_rdAddrA),
        .o_rdAddrB  (w_rdAddrB),
        .o_lastPair (w_lastPair)
    );

    // A zero-length job skips the MAC entirely and reports +0 straight away.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_macClkNum <= '0;
            r_outData   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.job_valid) begin
                        r_macClkNum <= bus.job_len;
                        if (bus.job_len == '0) begin
                            r_outData <= '0;
                            r_state   <= ST_OUT;
                        end else begin
                            r_state   <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (w_lastPair) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (bus.mac_result_ready) begin
                        r_outData <= w_capture;
                        r_state   <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Buffer data is only loaded in the cycle after a read; otherwise zeros keep the MAC quiet.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdEnD <= 1'b0;
            r_macA  <= '0;
            r_macB  <= '0;
        end else begin
            r_rdEnD <= w_fetch;
            r_macA  <= r_rdEnD ? bus.rd_data_a : '0;
            r_macB  <= r_rdEnD ? bus.rd_data_b : '0;
        end
    end

    assign bus.job_ready   = (r_state == ST_IDLE);
    assign bus.rd_en       = w_fetch;
    assign bus.rd_addr_a   = w_rdAddrA;
    assign bus.rd_addr_b   = w_rdAddrB;
    assign bus.mac_a       = r_macA;
    assign bus.mac_b       = r_macB;
    assign bus.mac_clk_num = r_macClkNum;
    assign bus.out_valid   = (r_state == ST_OUT);
    assign bus.out_data    = r_outData;
    assign bus.busy        = (r_state != ST_IDLE);

endmodule
